e_mdu_ctrl: RTL and testbench
=============================

E_MDU_CTRL -- requirements
Module: e_mdu_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5: busy cycles for mult/multu; SHALL be 1 or greater.
REQ-002 Parameter DIV_CYC, default 10: busy cycles for div/divu; SHALL be 1 or greater.
REQ-003 Parameter CNT_W, default 4: countdown counter width; SHALL hold max(MULT_CYC, DIV_CYC).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 INSTR_E  in  32  instruction in E stage.
REQ-007 INSTR_D  in  32  instruction in D stage, used for stall detection.
REQ-008 start  out  1  combinational one-cycle pulse launching a mult/div.
REQ-009 md_op  out  3  latched operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu.
REQ-010 busy  out  1  registered; high while an operation runs.
REQ-011 hi_we  out  1  HI write enable.
REQ-012 lo_we  out  1  LO write enable.
REQ-013 stall_md  out  1  D-stage stall request.
REQ-014 HLSel_E  out  2  01 selects mfhi, 10 selects mflo, 00 none.
REQ-015 RFWr_E  out  1  register-file write for mfhi/mflo.
REQ-016 Tnew_E  out  3  001 for mfhi/mflo, else 000.

Function
REQ-017 Decode SHALL use opcode 000000 with func: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
REQ-018 The FSM SHALL have two states: IDLE and BUSY.
REQ-019 In IDLE with a mult/multu/div/divu in INSTR_E, the block SHALL:
- assert start combinationally in that cycle;
- load the counter with MULT_CYC or DIV_CYC;
- latch md_op;
- enter BUSY at the next edge.
REQ-020 In BUSY, the counter SHALL decrement by 1 each cycle.
REQ-021 When the counter equals 1, the block SHALL assert hi_we and lo_we together for that cycle and return to IDLE at the next edge.
REQ-022 On return to IDLE, md_op SHALL clear to 0.
REQ-023 Latency: start at cycle t gives busy=1 for cycles t+1..t+N, hi_we/lo_we at cycle t+N, and busy=0 at t+N+1 (N = MULT_CYC or DIV_CYC).
REQ-024 A mult/div in INSTR_E while BUSY SHALL be ignored: no restart, no counter reload, md_op unchanged.
REQ-025 In IDLE, mthi SHALL assert hi_we only, and mtlo SHALL assert lo_we only, combinationally for one cycle, with no state change.
REQ-026 stall_md SHALL equal (INSTR_D is any of the eight MD instructions) AND (start OR busy).
REQ-027 In the completion cycle stall_md SHALL remain asserted; it SHALL release in the following cycle.
REQ-028 HLSel_E, RFWr_E and Tnew_E SHALL depend on INSTR_E only (combinational) and SHALL be independent of FSM state.
REQ-029 Instructions outside the eight MD instructions SHALL produce start=0, hi_we=0, lo_we=0 and RFWr_E=0.

Reset
REQ-030 Asserting reset SHALL, immediately and independent of clk:
- force IDLE;
- clear the counter to 0;
- set md_op=0 and busy=0.
REQ-031 Reset mid-operation SHALL abort the operation with no hi_we/lo_we pulse; after reset release, stall_md SHALL be 0 unless start is asserted.
REQ-032 Combinational outputs SHALL follow REQ-017..029 during reset, with busy treated as 0.

Verification
REQ-033 Defaults: mult in E at cycle 0 -> start=1 at cycle 0, busy=1 for cycles 1..5, hi_we=lo_we=1 at cycle 5, busy=0 at cycle 6, md_op=1 for cycles 1..5.
REQ-034 divu in E, then mflo held in D -> stall_md=1 for cycles 0..10, 0 at cycle 11; hi_we/lo_we at cycle 10; md_op=4.
REQ-035 mtlo in E while IDLE -> lo_we=1 and hi_we=0 for one cycle; busy stays 0; with add in D, stall_md=0.
REQ-036 Reset asserted mid-clock at cycle 3 of a div -> busy=0 and md_op=0 immediately; no hi_we/lo_we pulse occurs; the counter reads 0.
REQ-037 div in E while BUSY from a prior mult -> no start, no counter reload; completion still occurs at the original mult cycle.
REQ-038 MULT_CYC=1 -> start at t, busy=1 and hi_we=lo_we=1 at t+1 only; mfhi in E -> HLSel_E=01, RFWr_E=1, Tnew_E=001.

Source files
------------

// File: rtl/e_mdu_ctrl.sv
// Multiply/divide unit controller: decodes MD instructions in E, sequences a fixed-latency busy window
// and raises the HI/LO write enables and the D-stage stall request.
module e_mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] INSTR_E,
  input  logic [31:0] INSTR_D,
  output logic        start,
  output logic [2:0]  md_op,
  output logic        busy,
  output logic        hi_we,
  output logic        lo_we,
  output logic        stall_md,
  output logic [1:0]  HLSel_E,
  output logic        RFWr_E,
  output logic [2:0]  Tnew_E
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       md_op_q, md_op_d;

  logic [2:0] e_op;
  logic       e_mthi, e_mtlo, e_mfhi, e_mflo;
  logic       d_is_md;
  logic       in_idle, last_cyc;

  // Only opcode and func take part in decode; register fields are don't-care here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{INSTR_E[25:6], INSTR_D[25:6]};

  always_comb begin
    e_op    = OP_NONE;
    e_mthi  = 1'b0;
    e_mtlo  = 1'b0;
    e_mfhi  = 1'b0;
    e_mflo  = 1'b0;
    d_is_md = 1'b0;
    if (INSTR_E[31:26] == 6'b000000) begin
      case (INSTR_E[5:0])
        F_MULT:  e_op   = OP_MULT;
        F_MULTU: e_op   = OP_MULTU;
        F_DIV:   e_op   = OP_DIV;
        F_DIVU:  e_op   = OP_DIVU;
        F_MTHI:  e_mthi = 1'b1;
        F_MTLO:  e_mtlo = 1'b1;
        F_MFHI:  e_mfhi = 1'b1;
        F_MFLO:  e_mflo = 1'b1;
        default: ;
      endcase
    end
    if (INSTR_D[31:26] == 6'b000000) begin
      d_is_md = INSTR_D[5:0] inside {F_MULT, F_MULTU, F_DIV, F_DIVU,
                                     F_MFHI, F_MTHI, F_MFLO, F_MTLO};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      md_op_q <= OP_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_op_q <= md_op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_op_d = md_op_q;
    case (state_q)
      S_IDLE: begin
        if (e_op != OP_NONE) begin
          state_d = S_BUSY;
          cnt_d   = (e_op == OP_MULT || e_op == OP_MULTU) ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
          md_op_d = e_op;
        end
      end
      S_BUSY: begin
        // New mult/div in E is deliberately ignored here; the running op owns the counter.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          md_op_d = OP_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_idle  = (state_q == S_IDLE);
    last_cyc = (state_q == S_BUSY) && (cnt_q == CNT_W'(1));
    start    = in_idle && (e_op != OP_NONE);
    busy     = (state_q == S_BUSY);
    md_op    = md_op_q;
    hi_we    = last_cyc || (in_idle && e_mthi);
    lo_we    = last_cyc || (in_idle && e_mtlo);
    stall_md = d_is_md && (start || busy);
    HLSel_E  = {e_mflo, e_mfhi};
    RFWr_E   = e_mfhi || e_mflo;
    Tnew_E   = (e_mfhi || e_mflo) ? 3'b001 : 3'b000;
  end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Scoreboard bench for e_mdu_ctrl: default instance plus a MULT_CYC=1 instance,
// per-cycle expected observations queued by the stimulus and checked by negedge monitors.
module tb_e_mdu_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] ADD   = 32'h0085_1020;
  localparam logic [31:0] MULT  = 32'h0085_0018;
  localparam logic [31:0] MULTU = 32'h0085_0019;
  localparam logic [31:0] DIV   = 32'h0085_001A;
  localparam logic [31:0] DIVU  = 32'h0085_001B;
  localparam logic [31:0] MFHI  = 32'h0000_4010;
  localparam logic [31:0] MTHI  = 32'h0220_0011;
  localparam logic [31:0] MFLO  = 32'h0000_4012;
  localparam logic [31:0] MTLO  = 32'h0220_0013;
  localparam logic [31:0] LWX   = 32'h8C85_0018;  // non-R opcode whose low bits look like mult

  typedef struct packed {
    logic       start, busy, hi_we, lo_we, stall;
    logic [2:0] md_op;
    logic [1:0] hl;
    logic       rfwr;
    logic [2:0] tnew;
    logic [3:0] cnt;
  } obs_t;

  typedef struct packed {
    int   id;
    obs_t o;
  } ent_t;

  logic        clk, reset;
  logic [31:0] e0, d0, e1, d1;
  logic        start0, busy0, hi0, lo0, stall0, rf0;
  logic        start1, busy1, hi1, lo1, stall1, rf1;
  logic [2:0]  op0, tn0, op1, tn1;
  logic [1:0]  hl0, hl1;

  ent_t q0[$];
  ent_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_id  = 0;

  e_mdu_ctrl dut (
    .clk(clk), .reset(reset), .INSTR_E(e0), .INSTR_D(d0),
    .start(start0), .md_op(op0), .busy(busy0), .hi_we(hi0), .lo_we(lo0),
    .stall_md(stall0), .HLSel_E(hl0), .RFWr_E(rf0), .Tnew_E(tn0)
  );

  e_mdu_ctrl #(.MULT_CYC(1), .DIV_CYC(10), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .INSTR_E(e1), .INSTR_D(d1),
    .start(start1), .md_op(op1), .busy(busy1), .hi_we(hi1), .lo_we(lo1),
    .stall_md(stall1), .HLSel_E(hl1), .RFWr_E(rf1), .Tnew_E(tn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t got0, got1;
  assign got0 = {start0, busy0, hi0, lo0, stall0, op0, hl0, rf0, tn0, dut.cnt_q};
  assign got1 = {start1, busy1, hi1, lo1, stall1, op1, hl1, rf1, tn1, dut1.cnt_q};

  // Expected {HLSel_E, RFWr_E, Tnew_E} for the E-stage instruction.
  function automatic logic [5:0] e_side(input logic [31:0] e);
    if (e == MFHI) return 6'b01_1_001;
    if (e == MFLO) return 6'b10_1_001;
    return 6'b00_0_000;
  endfunction

  task automatic check(input int which, input int id, input obs_t got, input obs_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL dut%0d step%0d: got %b expected %b (start,busy,hi_we,lo_we,stall,md_op,hl,rfwr,tnew,cnt)",
                  which, id, got, exp);
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) begin
      ent_t x;
      x = q0.pop_front();
      check(0, x.id, got0, x.o);
    end
  end

  always @(negedge clk) begin
    if (q1.size() > 0) begin
      ent_t x;
      x = q1.pop_front();
      check(1, x.id, got1, x.o);
    end
  end

  // One clock cycle of stimulus: inputs after the edge, reset a little later, expectation queued.
  task automatic cyc(input int which, input logic [31:0] e, input logic [31:0] d, input logic r,
                     input logic st, input logic bz, input logic hw, input logic lw, input logic sl,
                     input logic [2:0] op, input logic [3:0] cnt);
    ent_t x;
    @(posedge clk);
    #1;
    if (which == 0) begin e0 = e; d0 = d; end
    else            begin e1 = e; d1 = d; end
    #1;
    reset = r;
    x.id = step_id;
    x.o  = {st, bz, hw, lw, sl, op, e_side(e), cnt};
    step_id++;
    if (which == 0) q0.push_back(x);
    else            q1.push_back(x);
  endtask

  initial begin
    reset = 1'b0;
    e0 = NOP; d0 = NOP; e1 = NOP; d1 = NOP;
    #2 reset = 1'b1;

    cyc(0, NOP, NOP, 1, 0,0,0,0,0, 0, 0);
    cyc(0, NOP, NOP, 1, 0,0,0,0,0, 0, 0);
    cyc(0, NOP, NOP, 0, 0,0,0,0,0, 0, 0);

    // Default mult: start at 0, busy 1..5, write at 5, idle at 6
    cyc(0, MULT, NOP, 0, 1,0,0,0,0, 0, 0);
    for (int k = 1; k <= 4; k++) cyc(0, NOP, NOP, 0, 0,1,0,0,0, 1, 4'(6 - k));
    cyc(0, NOP, NOP, 0, 0,1,1,1,0, 1, 1);
    cyc(0, NOP, NOP, 0, 0,0,0,0,0, 0, 0);

    // divu with mflo waiting in D
    cyc(0, DIVU, MFLO, 0, 1,0,0,0,1, 0, 0);
    for (int k = 1; k <= 9; k++) cyc(0, NOP, MFLO, 0, 0,1,0,0,1, 4, 4'(11 - k));
    cyc(0, NOP, MFLO, 0, 0,1,1,1,1, 4, 1);
    cyc(0, MFLO, MFLO, 0, 0,0,0,0,0, 0, 0);

    // Idle moves/reads and non-MD instructions
    cyc(0, MTLO, ADD,  0, 0,0,0,1,0, 0, 0);
    cyc(0, MTHI, NOP,  0, 0,0,1,0,0, 0, 0);
    cyc(0, MFHI, MTHI, 0, 0,0,0,0,0, 0, 0);
    cyc(0, LWX,  MULT, 0, 0,0,0,0,0, 0, 0);
    cyc(0, ADD,  NOP,  0, 0,0,0,0,0, 0, 0);

    // div arriving while a multu runs is ignored
    cyc(0, MULTU, MULTU, 0, 1,0,0,0,1, 0, 0);
    cyc(0, NOP,   NOP,   0, 0,1,0,0,0, 2, 5);
    cyc(0, DIV,   NOP,   0, 0,1,0,0,0, 2, 4);
    cyc(0, DIV,   DIV,   0, 0,1,0,0,1, 2, 3);
    cyc(0, NOP,   NOP,   0, 0,1,0,0,0, 2, 2);
    cyc(0, NOP,   NOP,   0, 0,1,1,1,0, 2, 1);
    cyc(0, NOP,   NOP,   0, 0,0,0,0,0, 0, 0);

    // Reset in the middle of cycle 3 of a div aborts it
    cyc(0, DIV, NOP,  0, 1,0,0,0,0, 0, 0);
    cyc(0, NOP, MFHI, 0, 0,1,0,0,1, 3, 10);
    cyc(0, NOP, MFHI, 0, 0,1,0,0,1, 3, 9);
    cyc(0, NOP, MFHI, 1, 0,0,0,0,0, 0, 0);
    for (int k = 0; k < 12; k++) cyc(0, NOP, MFHI, 0, 0,0,0,0,0, 0, 0);
    cyc(0, MULT, MFHI, 0, 1,0,0,0,1, 0, 0);
    for (int k = 1; k <= 4; k++) cyc(0, NOP, NOP, 0, 0,1,0,0,0, 1, 4'(6 - k));
    cyc(0, NOP, NOP, 0, 0,1,1,1,0, 1, 1);
    cyc(0, NOP, NOP, 0, 0,0,0,0,0, 0, 0);

    // MULT_CYC=1 instance
    cyc(1, NOP,  NOP,  0, 0,0,0,0,0, 0, 0);
    cyc(1, MULT, NOP,  0, 1,0,0,0,0, 0, 0);
    cyc(1, NOP,  MULT, 0, 0,1,1,1,1, 1, 1);
    cyc(1, MFHI, MULT, 0, 0,0,0,0,0, 0, 0);
    cyc(1, NOP,  NOP,  0, 0,0,0,0,0, 0, 0);

    for (int k = 0; k < 20 && (q0.size() > 0 || q1.size() > 0); k++) @(negedge clk);
    #1;
    if (q0.size() > 0 || q1.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q0.size() + q1.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
